// File: rtl/e203_subsys_clksw_ctrl.sv
// Core clock source sequencer: moves the glitch-free mux between the reference clock and the PLL,
// qualifies PLL lock before switching, and falls back to the reference clock on lock loss.
module e203_subsys_clksw_ctrl #(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned CNT_W        = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic done_valid,
    output logic done_err,
    output logic pll_en,
    input  logic pll_lock,
    output logic sel1,
    output logic cur_sel,
    output logic busy,
    output logic lock_lost,
    input  logic lock_lost_clr
);

    typedef enum logic [1:0] {StIdle, StLockWait, StSettle1, StSettle0} state_e;

    localparam logic [CNT_W-1:0] StabLast = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TmoLast  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SetLast  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e             state_q, state_d;
    logic               lock_meta_q, lock_meta_d;
    logic               lock_s_q, lock_s_d;
    logic               sel1_q, sel1_d;
    logic               pll_en_q, pll_en_d;
    logic               cur_sel_q, cur_sel_d;
    logic               lock_lost_q, lock_lost_d;
    logic               done_valid_q, done_valid_d;
    logic               done_err_q, done_err_d;
    logic               err_q, err_d;
    logic               auto_q, auto_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [CNT_W-1:0]   set_cnt_q, set_cnt_d;
    logic               fallback;
    logic               accept;

    // Running on the PLL without a synchronized lock forces a return to the reference clock.
    assign fallback = cur_sel_q & ~lock_s_q;
    assign accept   = (state_q == StIdle) & ~fallback & req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            sel1_q       <= 1'b0;
            pll_en_q     <= 1'b0;
            cur_sel_q    <= 1'b0;
            lock_lost_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            err_q        <= 1'b0;
            auto_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            stab_cnt_q   <= '0;
            set_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            sel1_q       <= sel1_d;
            pll_en_q     <= pll_en_d;
            cur_sel_q    <= cur_sel_d;
            lock_lost_q  <= lock_lost_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            err_q        <= err_d;
            auto_q       <= auto_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            set_cnt_q    <= set_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_meta_d  = pll_lock;
        lock_s_d     = lock_meta_q;
        sel1_d       = sel1_q;
        pll_en_d     = pll_en_q;
        cur_sel_d    = cur_sel_q;
        lock_lost_d  = lock_lost_q;
        done_valid_d = 1'b0;
        done_err_d   = 1'b0;
        err_d        = err_q;
        auto_d       = auto_q;
        tmo_cnt_d    = tmo_cnt_q;
        stab_cnt_d   = stab_cnt_q;
        set_cnt_d    = set_cnt_q;

        if (lock_lost_clr) begin
            lock_lost_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (fallback) begin
                    sel1_d      = 1'b0;
                    lock_lost_d = 1'b1;
                    auto_d      = 1'b1;
                    err_d       = 1'b0;
                    set_cnt_d   = '0;
                    state_d     = StSettle0;
                end else if (accept) begin
                    if (req_sel == cur_sel_q) begin
                        done_valid_d = 1'b1;
                    end else if (req_sel) begin
                        pll_en_d   = 1'b1;
                        tmo_cnt_d  = '0;
                        stab_cnt_d = '0;
                        state_d    = StLockWait;
                    end else begin
                        sel1_d    = 1'b0;
                        set_cnt_d = '0;
                        err_d     = 1'b0;
                        auto_d    = 1'b0;
                        state_d   = StSettle0;
                    end
                end
            end
            StLockWait: begin
                tmo_cnt_d  = tmo_cnt_q + CntOne;
                stab_cnt_d = lock_s_q ? stab_cnt_q + CntOne : '0;
                // A qualified lock on the final timeout cycle still completes the switch.
                if (lock_s_q && (stab_cnt_q == StabLast)) begin
                    sel1_d    = 1'b1;
                    set_cnt_d = '0;
                    state_d   = StSettle1;
                end else if (tmo_cnt_q == TmoLast) begin
                    pll_en_d     = 1'b0;
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b1;
                    state_d      = StIdle;
                end
            end
            StSettle1: begin
                if (!lock_s_q) begin
                    sel1_d    = 1'b0;
                    err_d     = 1'b1;
                    auto_d    = 1'b0;
                    set_cnt_d = '0;
                    state_d   = StSettle0;
                end else if (set_cnt_q == SetLast) begin
                    cur_sel_d    = 1'b1;
                    done_valid_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    set_cnt_d = set_cnt_q + CntOne;
                end
            end
            StSettle0: begin
                if (set_cnt_q == SetLast) begin
                    pll_en_d     = 1'b0;
                    cur_sel_d    = 1'b0;
                    done_valid_d = ~auto_q;
                    done_err_d   = ~auto_q & err_q;
                    state_d      = StIdle;
                end else begin
                    set_cnt_d = set_cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle) & ~fallback;
        busy       = (state_q != StIdle);
        done_valid = done_valid_q;
        done_err   = done_err_q;
        pll_en     = pll_en_q;
        sel1       = sel1_q;
        cur_sel    = cur_sel_q;
        lock_lost  = lock_lost_q;
    end

endmodule

// File: tb/tb_e203_subsys_clksw_ctrl.sv
// Directed bench for the clock switch sequencer: a request table plus hand-timed corner sequences.
module tb_e203_subsys_clksw_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_sel = 1'b0;
    logic pll_lock = 1'b0;
    logic lock_lost_clr = 1'b0;
    logic req_ready, done_valid, done_err, pll_en, sel1, cur_sel, busy, lock_lost;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic lock;
        logic sel;
        int   lat;
        logic err;
        logic cur;
        logic pen;
        logic s1;
    } vec_t;

    vec_t vecs[5];

    e203_subsys_clksw_ctrl #(
        .LOCK_STABLE  (16),
        .LOCK_TIMEOUT (1024),
        .SETTLE_CYC   (8),
        .CNT_W        (11)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_sel       (req_sel),
        .req_ready     (req_ready),
        .done_valid    (done_valid),
        .done_err      (done_err),
        .pll_en        (pll_en),
        .pll_lock      (pll_lock),
        .sel1          (sel1),
        .cur_sel       (cur_sel),
        .busy          (busy),
        .lock_lost     (lock_lost),
        .lock_lost_clr (lock_lost_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The mux select must never point at the PLL while it is powered down.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (sel1 && !pll_en) begin
                errors++;
                $display("FAIL sel1_without_pll_en: sel1 %0d pll_en %0d at %0t", sel1, pll_en,
                         $time);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        req_valid = 1'b0;
        req_sel = 1'b0;
        lock_lost_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request; latency counts cycles from the accept edge to the visible done pulse.
    task automatic run_req(input logic sel, input int budget, output int lat, output logic err);
        lat = -1;
        err = 1'bx;
        @(negedge clk);
        chk("ready_at_accept", req_ready, 1);
        req_valid = 1'b1;
        req_sel = sel;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done_valid) begin
                lat = c;
                err = done_err;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        logic err;
        int   s1c;
        int   dnc;
        int   seen_done;

        vecs[0] = '{1'b0, 1'b0, 1,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 25,   1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1,    1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 9,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1025, 1'b1, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk("rst_sel1", sel1, 0);
        chk("rst_pll_en", pll_en, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lock_lost", lock_lost, 0);

        for (int i = 0; i < 5; i++) begin
            pll_lock = vecs[i].lock;
            repeat (4) @(negedge clk);
            run_req(vecs[i].sel, 1100, lat, err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_done_err", i), err, vecs[i].err);
            chk($sformatf("vec%0d_cur_sel", i), cur_sel, vecs[i].cur);
            chk($sformatf("vec%0d_pll_en", i), pll_en, vecs[i].pen);
            chk($sformatf("vec%0d_sel1", i), sel1, vecs[i].s1);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), done_valid, 0);
        end

        // Lock arrives mid-qualification: rises in cycle 10, synchronized in cycle 12.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_sel = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        s1c = -1;
        dnc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) chk("seqA_pll_en_c1", pll_en, 1);
            if (c == 10) pll_lock = 1'b1;
            if (sel1 && s1c < 0) s1c = c;
            if (done_valid) begin
                dnc = c;
                chk("seqA_done_err", done_err, 0);
                break;
            end
        end
        chk("seqA_sel1_cycle", s1c, 28);
        chk("seqA_done_cycle", dnc, 36);
        chk("seqA_cur_sel", cur_sel, 1);

        // Lock loss while on the PLL; the clear is held across the set cycle and must lose.
        @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("seqC_ready_blocked", req_ready, 0);
        chk("seqC_idle_at_detect", busy, 0);
        req_valid = 1'b1;
        req_sel = 1'b0;
        lock_lost_clr = 1'b1;
        seen_done = 0;
        for (int c = 3; c <= 11; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("seqC_sel1_dropped", sel1, 0);
                chk("seqC_lock_lost_set_wins", lock_lost, 1);
                chk("seqC_busy", busy, 1);
                chk("seqC_ready_busy", req_ready, 0);
                lock_lost_clr = 1'b0;
            end
            if (c == 10) chk("seqC_pll_en_held", pll_en, 1);
            if (done_valid) seen_done++;
        end
        chk("seqC_pll_en_off", pll_en, 0);
        chk("seqC_cur_sel", cur_sel, 0);
        chk("seqC_ready_after", req_ready, 1);
        chk("seqC_no_done_pulse", seen_done, 0);
        chk("seqC_lock_lost_sticky", lock_lost, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("seqC_req_done", done_valid, 1);
        chk("seqC_req_err", done_err, 0);
        lock_lost_clr = 1'b1;
        @(negedge clk);
        lock_lost_clr = 1'b0;
        chk("seqC_lock_lost_clr", lock_lost, 0);

        // Lock glitch: high cycles 5..14, low 15..17, high from 18; qualification restarts.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_sel = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        s1c = -1;
        dnc = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 5) pll_lock = 1'b1;
            if (c == 15) pll_lock = 1'b0;
            if (c == 18) pll_lock = 1'b1;
            if (sel1 && s1c < 0) s1c = c;
            if (done_valid) begin
                dnc = c;
                break;
            end
        end
        chk("seqB_sel1_cycle", s1c, 36);
        chk("seqB_done_cycle", dnc, 44);

        // Switch back to the reference clock, then reset in the middle of SETTLE1.
        @(negedge clk);
        req_valid = 1'b1;
        req_sel = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dnc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) chk("seqD_sel1_at_once", sel1, 0);
            if (c == 8) chk("seqD_pll_en_c8", pll_en, 1);
            if (done_valid) begin
                dnc = c;
                break;
            end
        end
        chk("seqD_done_cycle", dnc, 9);
        chk("seqD_pll_en_off", pll_en, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_sel = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        s1c = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (sel1) begin
                s1c = c;
                break;
            end
        end
        chk("seqD_sel1_locked_cycle", s1c, 17);
        repeat (2) @(negedge clk);
        chk("seqD_busy_settle1", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("seqD_rst_sel1", sel1, 0);
        chk("seqD_rst_pll_en", pll_en, 0);
        chk("seqD_rst_cur_sel", cur_sel, 0);
        chk("seqD_rst_req_ready", req_ready, 1);
        chk("seqD_rst_done_valid", done_valid, 0);
        chk("seqD_rst_done_err", done_err, 0);
        chk("seqD_rst_busy", busy, 0);
        chk("seqD_rst_lock_lost", lock_lost, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
